ysyx_22041207_mem_arb: RTL and testbench
========================================

YSYX_22041207_MEM_ARB -- requirements
Module: ysyx_22041207_mem_arb

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive LS grants tolerated while IF waits (range 1..15).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk in 1 (all state on posedge), rst in 1 (async, active-high).
REQ-003 SHALL have port: if_req  in  1  instruction-fetch request.
REQ-004 SHALL have port: if_addr  in  64  fetch address.
REQ-005 SHALL have port: if_flush  in  1  front-end flush; discards in-flight fetch result.
REQ-006 SHALL have port: if_gnt  out  1  fetch accepted (1-cycle pulse).
REQ-007 SHALL have ports: if_rvalid  out  1 and if_rdata  out  64, fetch data valid pulse and data.
REQ-008 SHALL have ports: ls_req  in  1 and ls_wen  in  1, load/store request and write-enable.
REQ-009 SHALL have ports: ls_addr  in  64, ls_wdata  in  64 and ls_wmask  in  8, LS address, write data and byte mask.
REQ-010 SHALL have ports: ls_gnt  out  1, ls_rvalid  out  1 and ls_rdata  out  64, LS accepted pulse, done pulse and read data.
REQ-011 SHALL have ports: mem_req  out  1, mem_wen  out  1, mem_addr  out  64, mem_wdata  out  64 and mem_wmask  out  8, the shared memory port.
REQ-012 SHALL have ports: mem_ready  in  1 and mem_rdata  in  64, memory completion and read data.

Function
REQ-013 SHALL implement FSM states IDLE, IF_BUSY and LS_BUSY, with one outstanding transaction at most.
REQ-014 SHALL, in IDLE with any request, grant exactly one requester, pulse its gnt that cycle, register its addr/wdata/wmask/wen, and move to the matching BUSY state.
REQ-015 SHALL give ls_req priority over if_req, except as in REQ-021.
REQ-016 SHALL drive mem_req=1 with the registered fields throughout BUSY, starting the cycle after the grant, and hold them until mem_ready.
REQ-017 SHALL, on mem_ready in BUSY, register mem_rdata to the owner's rdata, pulse the owner's rvalid the next cycle and return to IDLE; a new grant is allowed in that same cycle.
REQ-018 SHALL force mem_wen=0 and mem_wmask=0 for IF transactions; a LS write SHALL still produce ls_rvalid (rdata don't-care).
REQ-019 SHALL ignore mem_ready in IDLE, SHALL ignore requests while BUSY, and SHALL let requesters drop req before gnt without effect.
REQ-020 SHALL handle if_flush: in IF_BUSY, set a drop flag so the completing fetch produces no if_rvalid (memory cycle still completes); in IDLE, block if_req from being granted that cycle; a flush coinciding with mem_ready SHALL suppress that if_rvalid.
REQ-021 SHALL grant IF in IDLE when if_req=1 and the starvation count equals STARVE_LIMIT, even if ls_req=1.
REQ-022 SHALL increment the starvation count, saturating, on each LS grant while if_req=1, and SHALL clear it on any IF grant or whenever if_req=0 in IDLE.

Reset
REQ-023 SHALL, on rst, enter IDLE, clear counter and drop flag, and drive every output to 0 (mem_*, gnt, rvalid, rdata).
REQ-024 SHALL abandon any in-flight transaction on reset mid-operation without producing rvalid; mem_ready arriving after reset release SHALL be ignored.

Configuration
REQ-025 SHALL, with YSYX_22041207_ARB_FAIR_EN defined, implement REQ-021 and REQ-022.
REQ-026 SHALL, without YSYX_22041207_ARB_FAIR_EN, use strict LS priority with no counter logic, leaving STARVE_LIMIT unused.

Structure
REQ-027 SHALL place the FSM state enum, the owner code (NONE/IF/LS) and ADDR_W=64/DATA_W=64 in package ysyx_22041207_arb_pkg.
REQ-028 SHALL implement the saturating starvation counter as sub-module ysyx_22041207_starve_cnt, instantiated only under YSYX_22041207_ARB_FAIR_EN.

Verification
REQ-029 SHALL cover: if_req, if_addr=0x80000000, mem_ready 3 cycles later with rdata=0x00000013 -> if_gnt at cycle 0, mem_req cycles 1-3, if_rvalid=1 with if_rdata=0x13 at cycle 4.
REQ-030 SHALL cover: if_req and ls_req (wen=1, addr=0x80001000, wdata=0xDEAD, wmask=0x0F) in the same cycle -> ls_gnt first, mem_wen=1 and mem_wmask=0x0F, IF granted in the IDLE after ls_rvalid.
REQ-031 SHALL cover, with FAIR_EN and STARVE_LIMIT=4: ls_req and if_req held high -> 4 LS grants, then an IF grant, then the count restarts at 0.
REQ-032 SHALL cover: if_flush pulsed during IF_BUSY -> no if_rvalid on completion, and the next LS grant is unaffected.
REQ-033 SHALL cover: rst asserted in LS_BUSY, then mem_ready after release -> all outputs 0, state IDLE, no ls_rvalid.
REQ-034 SHALL cover: mem_ready held high in IDLE with no requests -> no rvalid and no state change.

Source files
------------

// File: rtl/ysyx_22041207_arb_pkg.sv
// Shared types and widths for the IF/LS memory arbiter.
package ysyx_22041207_arb_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = DATA_W / 8;
  // Starvation counter width; covers STARVE_LIMIT up to 15.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIfBusy = 2'd1,
    StLsBusy = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnLs   = 2'd2
  } owner_e;

endpackage

// File: rtl/ysyx_22041207_starve_cnt.sv
// Saturating count of LS grants issued while a fetch is waiting.
module ysyx_22041207_starve_cnt
  import ysyx_22041207_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LimitVal = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; stop counting once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LimitVal)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LimitVal);

endmodule

// File: rtl/ysyx_22041207_mem_arb.sv
// Two-requester (instruction fetch / load-store) arbiter for a single memory
// port with at most one outstanding transaction. LS has priority; defining
// YSYX_22041207_ARB_FAIR_EN adds a starvation guard that forces an IF grant
// after STARVE_LIMIT consecutive LS grants while IF is waiting.
module ysyx_22041207_mem_arb
  import ysyx_22041207_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("STARVE_LIMIT must be in 1..15");
  end

  arb_state_e        state_q, state_d;
  owner_e            pick;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic              wen_q;
  logic              drop_q;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
  logic              if_ok, force_if, busy, if_done, ls_done, if_deliver;

  // A flush in IDLE blocks the fetch from being granted that cycle.
  assign if_ok = if_req & ~if_flush;

`ifdef YSYX_22041207_ARB_FAIR_EN
  logic starve_inc, starve_clr;
  assign starve_inc = (pick == OwnLs) & if_req;
  assign starve_clr = (pick == OwnIf) | ((state_q == StIdle) & ~if_req);

  ysyx_22041207_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Grant selection and next state; grants are held off while reset is active.
  always_comb begin
    state_d = state_q;
    pick    = OwnNone;
    unique case (state_q)
      StIdle: begin
        if (!rst) begin
          if (if_ok && (!ls_req || force_if)) begin
            pick = OwnIf;
          end else if (ls_req) begin
            pick = OwnLs;
          end
        end
        if (pick == OwnIf) begin
          state_d = StIfBusy;
        end else if (pick == OwnLs) begin
          state_d = StLsBusy;
        end
      end
      StIfBusy, StLsBusy: begin
        if (mem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign if_done    = (state_q == StIfBusy) & mem_ready;
  assign ls_done    = (state_q == StLsBusy) & mem_ready;
  // A flush arriving with mem_ready still kills the fetch result.
  assign if_deliver = if_done & ~drop_q & ~if_flush;

  // State, latched request fields, drop flag and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      wen_q       <= 1'b0;
      drop_q      <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pick == OwnLs) begin
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
        wmask_q <= ls_wmask;
        wen_q   <= ls_wen;
      end else if (pick == OwnIf) begin
        addr_q  <= if_addr;
        wdata_q <= '0;
        wmask_q <= '0;
        wen_q   <= 1'b0;
      end
      if (state_q == StIfBusy) begin
        drop_q <= if_done ? 1'b0 : (drop_q | if_flush);
      end else begin
        drop_q <= 1'b0;
      end
      if_rvalid_q <= if_deliver;
      ls_rvalid_q <= ls_done;
      if (if_deliver) if_rdata_q <= mem_rdata;
      if (ls_done)    ls_rdata_q <= mem_rdata;
    end
  end

  assign if_gnt    = (pick == OwnIf);
  assign ls_gnt    = (pick == OwnLs);
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

  assign mem_req   = busy;
  assign mem_wen   = busy & wen_q;
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_wmask = busy ? wmask_q : '0;

endmodule

// File: tb/tb_ysyx_22041207_mem_arb.sv
// Directed bench for the IF/LS memory arbiter. Expected responses are queued
// by the stimulus and consumed by a monitor whenever an rvalid appears.
module tb_ysyx_22041207_mem_arb;

`ifdef YSYX_22041207_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req, mem_wen, mem_ready;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  ysyx_22041207_mem_arb #(
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_wen   (ls_wen),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_wmask (ls_wmask),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .mem_req  (mem_req),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rv(input bit is_if, input bit chk_data, input logic [63:0] data);
    exp_t e;
    e.is_if    = is_if;
    e.chk_data = chk_data;
    e.data     = data;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_req"},   mem_req,   64'd0);
    chk({tag, "_mem_wen"},   mem_wen,   64'd0);
    chk({tag, "_mem_addr"},  mem_addr,  64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_wmask"}, mem_wmask, 64'd0);
    chk({tag, "_if_gnt"},    if_gnt,    64'd0);
    chk({tag, "_ls_gnt"},    ls_gnt,    64'd0);
    chk({tag, "_if_rvalid"}, if_rvalid, 64'd0);
    chk({tag, "_ls_rvalid"}, ls_rvalid, 64'd0);
    chk({tag, "_if_rdata"},  if_rdata,  64'd0);
    chk({tag, "_ls_rdata"},  ls_rdata,  64'd0);
  endtask

  // Monitor: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_rvalid || ls_rvalid) begin
      if (if_rvalid && ls_rvalid) begin
        checks++;
        failures++;
        $display("FAIL both_rvalid: got if=1 ls=1 expected one owner");
      end else if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got if=%0b ls=%0b expected none", if_rvalid, ls_rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rvalid_owner_is_if", {63'd0, if_rvalid}, {63'd0, e.is_if});
        if (e.chk_data) chk("rvalid_rdata", if_rvalid ? if_rdata : ls_rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;  if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b0;

    // Single fetch, memory answers on cycle 3.
    if_req = 1'b1; if_addr = 64'h8000_0000;
    @(negedge clk);
    chk("t1_if_gnt_c0", if_gnt, 64'd1);
    chk("t1_ls_gnt_c0", ls_gnt, 64'd0);
    chk("t1_mem_req_c0", mem_req, 64'd0);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_req_c1", mem_req, 64'd1);
    chk("t1_mem_addr", mem_addr, 64'h8000_0000);
    chk("t1_mem_wen", mem_wen, 64'd0);
    tick();
    @(negedge clk);
    chk("t1_mem_req_c2", mem_req, 64'd1);
    tick(); mem_ready = 1'b1; mem_rdata = 64'h13; expect_rv(1'b1, 1'b1, 64'h13);
    @(negedge clk);
    chk("t1_mem_req_c3", mem_req, 64'd1);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    chk("t1_if_rvalid_c4", if_rvalid, 64'd1);
    chk("t1_mem_req_c4", mem_req, 64'd0);
    tick();

    // Simultaneous requests: LS write first, then IF in the following IDLE.
    if_req = 1'b1; if_addr = 64'h8000_0040;
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_1000; ls_wdata = 64'hDEAD; ls_wmask = 8'h0F;
    @(negedge clk);
    chk("t2_ls_gnt", ls_gnt, 64'd1);
    chk("t2_if_gnt_blocked", if_gnt, 64'd0);
    tick(); ls_req = 1'b0;
    @(negedge clk);
    chk("t2_mem_wen", mem_wen, 64'd1);
    chk("t2_mem_wmask", mem_wmask, 64'h0F);
    chk("t2_mem_addr", mem_addr, 64'h8000_1000);
    chk("t2_mem_wdata", mem_wdata, 64'hDEAD);
    chk("t2_if_gnt_busy", if_gnt, 64'd0);
    tick(); mem_ready = 1'b1; mem_rdata = 64'h5555; expect_rv(1'b0, 1'b0, 64'd0);
    tick(); mem_ready = 1'b0;
    @(negedge clk);
    chk("t2_ls_rvalid", ls_rvalid, 64'd1);
    chk("t2_if_gnt_after", if_gnt, 64'd1);
    tick(); if_req = 1'b0;
    @(negedge clk);
    chk("t2_if_mem_wen", mem_wen, 64'd0);
    chk("t2_if_mem_wmask", mem_wmask, 64'd0);
    chk("t2_if_mem_addr", mem_addr, 64'h8000_0040);
    tick(); mem_ready = 1'b1; mem_rdata = 64'h1234; expect_rv(1'b1, 1'b1, 64'h1234);
    tick(); mem_ready = 1'b0;
    tick();

    // Flush in IDLE blocks the grant; flush in IF_BUSY drops the result.
    if_req = 1'b1; if_addr = 64'h8000_0080; if_flush = 1'b1;
    @(negedge clk);
    chk("t3_flush_idle_gnt", if_gnt, 64'd0);
    tick(); if_flush = 1'b0;
    @(negedge clk);
    chk("t3_if_gnt", if_gnt, 64'd1);
    tick(); if_req = 1'b0; if_flush = 1'b1;
    tick(); if_flush = 1'b0;
    tick(); mem_ready = 1'b1; mem_rdata = 64'h77;
    tick(); mem_ready = 1'b0;
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h8000_2000;
    @(negedge clk);
    chk("t3_dropped_if_rvalid", if_rvalid, 64'd0);
    chk("t3_ls_gnt", ls_gnt, 64'd1);
    tick(); ls_req = 1'b0;
    @(negedge clk);
    chk("t3_ls_mem_addr", mem_addr, 64'h8000_2000);
    chk("t3_ls_mem_wen", mem_wen, 64'd0);
    tick(); mem_ready = 1'b1; mem_rdata = 64'hABCD; expect_rv(1'b0, 1'b1, 64'hABCD);
    tick(); mem_ready = 1'b0;
    tick();

    // Flush coinciding with mem_ready, then a clean fetch must still deliver.
    if_req = 1'b1; if_addr = 64'h8000_00C0;
    tick(); if_req = 1'b0; mem_ready = 1'b1; if_flush = 1'b1; mem_rdata = 64'h99;
    tick(); mem_ready = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    chk("t3_flush_ready_rvalid", if_rvalid, 64'd0);
    tick(); if_req = 1'b1; if_addr = 64'h8000_0100;
    tick(); if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 64'h42; expect_rv(1'b1, 1'b1, 64'h42);
    tick(); mem_ready = 1'b0;
    tick();

    // Reset in LS_BUSY, then mem_ready held after release (also IDLE idling).
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 64'h8000_3000; ls_wdata = 64'hBEEF; ls_wmask = 8'hFF;
    @(negedge clk);
    chk("t4_ls_gnt", ls_gnt, 64'd1);
    tick(); ls_req = 1'b0;
    @(negedge clk);
    chk("t4_mem_req_busy", mem_req, 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("t4_rst_mid");
    tick(); rst = 1'b0; mem_ready = 1'b1; mem_rdata = 64'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_idle_mem_req", mem_req, 64'd0);
      chk("t5_idle_ls_rvalid", ls_rvalid, 64'd0);
      chk("t5_idle_if_rvalid", if_rvalid, 64'd0);
      tick();
    end
    mem_ready = 1'b0;

    // Both requesters held high: LS priority, with IF forced in on the fifth grant when fair.
    ls_req = 1'b1; ls_wen = 1'b0; ls_addr = 64'h8000_4000; if_req = 1'b1; if_addr = 64'h8000_0200;
    for (int i = 0; i < 6; i++) begin
      bit exp_if;
      exp_if = FAIR && (i == 4);
      @(negedge clk);
      chk("t6_if_gnt", if_gnt, {63'd0, exp_if});
      chk("t6_ls_gnt", ls_gnt, {63'd0, !exp_if});
      tick(); mem_ready = 1'b1; mem_rdata = 64'h100 + 64'(i); expect_rv(exp_if, 1'b1, 64'h100 + 64'(i));
      tick(); mem_ready = 1'b0;
    end
    ls_req = 1'b0; if_req = 1'b0;
    repeat (3) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
